// File: rtl/fft_uart_tx.sv
// fft_uart_tx
// Result-return path of the FFT. It collects one frame of N complex output
// samples into two byte RAMs (real and imaginary). Each sample is shifted
// right arithmetically and saturated to a signed byte. The frame is then sent
// over an 8N1 UART, LSB first: the N real bytes in natural index order,
// followed by the N imaginary bytes.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   Re_i    signed real part of the FFT output sample
//   Im_i    signed imaginary part of the FFT output sample
//   addr_i  natural-order frequency index of the sample
//   en_i    sample valid, one sample per cycle
//   tx_o    UART serial output, idle high
//   busy_o  high from the first accepted sample until the frame completes
//   done_o  one-cycle pulse after the last stop bit
module fft_uart_tx #(
  parameter int              bit_width = 32,
  parameter int              N         = 16,
  parameter int              SIZE      = 4,
  parameter int              SHIFT     = 6,
  parameter logic [15:0]     t_1_bit   = 16'd5207
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [bit_width-1:0] Re_i,
  input  logic signed [bit_width-1:0] Im_i,
  input  logic        [SIZE-1:0]      addr_i,
  input  logic                        en_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [2:0] {IDLE, COLLECT, LOAD, START, DATA, STOP, DONE} state_t;

  localparam logic [15:0]                BAUD_LAST = t_1_bit - 16'd1;
  localparam logic [SIZE:0]              LAST_CNT  = (SIZE+1)'(N - 1);
  localparam logic signed [bit_width-1:0] S8_MAX   = bit_width'(127);
  localparam logic signed [bit_width-1:0] S8_MIN   = bit_width'(-128);

  state_t        state_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic [SIZE:0] count_q;
  logic [SIZE:0] rd_idx_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    byte_q;
  logic [7:0]    mem_re_q [N];
  logic [7:0]    mem_im_q [N];
  logic          wr_en;

  function automatic logic [7:0] sat8(input logic signed [bit_width-1:0] x);
    logic signed [bit_width-1:0] s;
    s = x >>> SHIFT;
    if (s > S8_MAX)      return 8'h7F;
    else if (s < S8_MIN) return 8'h80;
    else                 return s[7:0];
  endfunction

  // N is a power of two, so the top index bit selects the Im RAM and the low
  // bits are already idx-N for the second half.
  function automatic logic [7:0] rd_byte(input logic [SIZE:0] idx);
    if (idx[SIZE]) return mem_im_q[idx[SIZE-1:0]];
    else           return mem_re_q[idx[SIZE-1:0]];
  endfunction

  // Samples are only accepted while the frame is still being collected.
  assign wr_en = en_i && ((state_q == IDLE) || (state_q == COLLECT));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re_q[addr_i] <= sat8(Re_i);
      mem_im_q[addr_i] <= sat8(Im_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      rd_idx_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          count_q  <= '0;
          rd_idx_q <= '0;
          baud_q   <= '0;
          bit_q    <= '0;
          if (en_i) begin
            busy_q  <= 1'b1;
            count_q <= (SIZE+1)'(1);
            state_q <= (N == 1) ? LOAD : COLLECT;
          end
        end
        COLLECT: begin
          if (en_i) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_CNT) state_q <= LOAD;
          end
        end
        LOAD: begin
          byte_q  <= rd_byte(rd_idx_q);
          tx_q    <= 1'b0;
          baud_q  <= '0;
          state_q <= START;
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= byte_q[0];
            byte_q  <= byte_q >> 1;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q  <= bit_q + 3'd1;
              tx_q   <= byte_q[0];
              byte_q <= byte_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          // Next byte is fetched while the stop bit is on the line so the
          // following start bit can begin without a gap.
          byte_q <= rd_byte(rd_idx_q + 1'b1);
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (&rd_idx_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
              tx_q     <= 1'b0;
              state_q  <= START;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_fft_uart_tx.sv
// Self-checking bench for fft_uart_tx (N=4, SHIFT=6, 4 cycles per bit).
// A behavioural model converts samples with plain integer floor division and
// clamping; a cycle-level UART receiver checks every line cycle of each byte.
module tb_fft_uart_tx;
  localparam int N     = 4;
  localparam int SIZE  = 2;
  localparam int SHIFT = 6;
  localparam int TB    = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] re_i = '0;
  logic signed [31:0] im_i = '0;
  logic [SIZE-1:0]    addr_i = '0;
  logic               en_i = 1'b0;
  logic               tx_o, busy_o, done_o;

  int tests = 0;
  int fails = 0;

  logic signed [31:0] fr_re [N];
  logic signed [31:0] fr_im [N];
  int                 order [N];
  logic [7:0]         m_re [N];
  logic [7:0]         m_im [N];
  logic signed [31:0] bnd [10] = '{32'sd8128, 32'sd8191, 32'sd8192, -32'sd8192, -32'sd8193,
                                   -32'sd8256, 32'sd0, 32'sd63, -32'sd1, -32'sd65};

  always #5 clk = ~clk;

  fft_uart_tx #(.bit_width(32), .N(N), .SIZE(SIZE), .SHIFT(SHIFT), .t_1_bit(16'd4)) dut (
    .clk(clk), .rst(rst), .Re_i(re_i), .Im_i(im_i), .addr_i(addr_i),
    .en_i(en_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor division by 2^SHIFT, then clamp to the signed byte range.
  function automatic logic [7:0] model_byte(input logic signed [31:0] x);
    longint v, d, s;
    v = longint'(x);
    d = longint'(1) << SHIFT;
    s = v / d;
    if (v < 0 && (v % d) != 0) s = s - 1;
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
    return 8'(s);
  endfunction

  function automatic logic signed [31:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return $signed($urandom);
      1:       return 32'($urandom_range(0, 20000)) - 32'sd10000;
      2:       return bnd[$urandom_range(0, 9)];
      default: return 32'($urandom_range(0, 16383)) - 32'sd8192;
    endcase
  endfunction

  task automatic randomize_frame();
    int j, t;
    for (int i = 0; i < N; i++) begin
      fr_re[i] = rand_sample();
      fr_im[i] = rand_sample();
      order[i] = i;
    end
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
  endtask

  // Leaves the bench at the negedge just after the Nth en_i was sampled.
  task automatic send_samples(input int gap, input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, "_busy_pre"}, 32'(busy_o), 32'd0);
      en_i   = 1'b1;
      addr_i = SIZE'(order[i]);
      re_i   = fr_re[order[i]];
      im_i   = fr_im[order[i]];
      m_re[order[i]] = model_byte(fr_re[order[i]]);
      m_im[order[i]] = model_byte(fr_im[order[i]]);
      @(negedge clk);
      en_i = 1'b0;
      if (i == 0) chk({tag, "_busy_rise"}, 32'(busy_o), 32'd1);
      if (i < N - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int gap, input bit noise, input string tag);
    int         w;
    int         bad, busy_bad, done_bad;
    logic       lvl;
    logic [7:0] exp, got;
    send_samples(gap, tag);
    chk({tag, "_tx_load"}, 32'(tx_o), 32'd1);
    w = 0;
    while (tx_o !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_latency"}, 32'(w), 32'd1);
    if (tx_o !== 1'b0) return;
    busy_bad = 0;
    done_bad = 0;
    for (int b = 0; b < 2 * N; b++) begin
      exp = (b < N) ? m_re[b] : m_im[b - N];
      got = '0;
      bad = 0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int c = 0; c < TB; c++) begin
          lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp[bi - 1];
          if (tx_o !== lvl) bad++;
          if (c == TB / 2 && bi >= 1 && bi <= 8) got[bi - 1] = tx_o;
          if (busy_o !== 1'b1) busy_bad++;
          if (done_o !== 1'b0) done_bad++;
          if (noise && b < 2 * N - 1) begin
            en_i   = 1'($urandom_range(0, 1));
            addr_i = SIZE'($urandom_range(0, N - 1));
            re_i   = $signed($urandom);
            im_i   = $signed($urandom);
          end else begin
            en_i = 1'b0;
          end
          @(negedge clk);
        end
      end
      chk($sformatf("%s_byte%0d", tag, b), 32'(got), 32'(exp));
      chk($sformatf("%s_frame%0d", tag, b), 32'(bad), 32'd0);
    end
    chk({tag, "_busy_hold"}, 32'(busy_bad), 32'd0);
    chk({tag, "_done_early"}, 32'(done_bad), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd1);
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(done_o), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
    chk({tag, "_tx_idle"}, 32'(tx_o), 32'd1);
  endtask

  initial begin
    int errs;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx_o), 32'd1);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame: required bytes 01 02 FF 00 00 03 FE 05
    fr_re = '{32'sd64, 32'sd128, -32'sd64, 32'sd0};
    fr_im = '{32'sd0, 32'sd192, -32'sd128, 32'sd320};
    order = '{0, 1, 2, 3};
    run_frame(0, 1'b0, "basic");
    chk("basic_model_b2", 32'(m_re[2]), 32'h0000_00FF);
    chk("basic_model_b7", 32'(m_im[3]), 32'h0000_0005);

    // Scrambled address order, same data
    order = '{0, 2, 1, 3};
    run_frame(0, 1'b0, "scramble");

    // Saturation and boundary conversions
    fr_re = '{32'sh0001_0000, 32'sd8128, -32'sd8192, 32'sd8192};
    fr_im = '{-32'sh0001_0000, -32'sd8256, 32'sd8191, -32'sd8193};
    order = '{3, 1, 0, 2};
    run_frame(0, 1'b0, "sat");
    chk("sat_re0", 32'(m_re[0]), 32'h0000_007F);
    chk("sat_im0", 32'(m_im[0]), 32'h0000_0080);

    // Gapped input
    randomize_frame();
    run_frame(3, 1'b0, "gapped");

    // en_i pulses during transmission must be ignored
    randomize_frame();
    run_frame(1, 1'b1, "noise");

    // Reset in the middle of a transmission
    randomize_frame();
    send_samples(0, "rstmid");
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", 32'(tx_o), 32'd1);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) errs++;
      @(negedge clk);
    end
    chk("rstmid_quiet", 32'(errs), 32'd0);

    // Random frames after the abort
    for (int f = 0; f < 3; f++) begin
      randomize_frame();
      run_frame($urandom_range(0, 2), 1'(f % 2), $sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
